// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: captures the IP-mode fetch address, runs byte reads
// from memory and buffers the bytes in a small first-word-fall-through FIFO.
module prefetch_queue #(
    parameter int unsigned DEPTH = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] Direction,
    input  logic        flush,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        q_pop,
    output logic [7:0]  q_data,
    output logic        q_valid,
    output logic [2:0]  q_count
);

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [AW-1:0]   fptr, fptr_d;
    logic [IW-1:0]   wr_idx, wr_d;
    logic [IW-1:0]   rd_idx, rd_d;
    logic [CW-1:0]   count_d;
    logic [AW-1:0]   mem_addr_d;
    logic [DW-1:0]   q_data_d;
    logic            mem_req_d;
    logic            q_valid_d;
    logic            push;
    logic            pop;
    logic [DW-1:0]   mem [DEPTH];

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
    endfunction

    // Next-state, pointer bookkeeping and registered-output values
    always_comb begin
        state_d    = state;
        fptr_d     = fptr;
        wr_d       = wr_idx;
        rd_d       = rd_idx;
        count_d    = q_count;
        push       = mem_req && mem_ack;
        pop        = q_pop && (q_count != '0);

        case (state)
            LOAD:    begin
                fptr_d  = Direction;
                state_d = FETCH;
            end
            FETCH:   if (push) fptr_d = fptr + AW'(1);
            FULL:    if (pop) state_d = FETCH;
            default: state_d = LOAD;
        endcase

        if (push) wr_d = next_idx(wr_idx);
        if (pop)  rd_d = next_idx(rd_idx);
        if (push && !pop)      count_d = q_count + CW'(1);
        else if (pop && !push) count_d = q_count - CW'(1);

        if (state == FETCH && count_d == CW'(DEPTH)) state_d = FULL;

        // A request is outstanding in every FETCH cycle; the address tracks fptr
        mem_req_d  = (state_d == FETCH);
        mem_addr_d = fptr_d;
        q_valid_d  = (count_d != '0);
        q_data_d   = (push && wr_idx == rd_d) ? mem_rdata : mem[rd_d];
    end

    // State register and all datapath registers; flush outranks every other update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            fptr     <= '0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            q_count  <= '0;
            q_valid  <= 1'b0;
            q_data   <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            state    <= LOAD;
            wr_idx   <= '0;
            rd_idx   <= '0;
            q_count  <= '0;
            q_valid  <= 1'b0;
            q_data   <= '0;
            mem_req  <= 1'b0;
        end else begin
            state    <= state_d;
            fptr     <= fptr_d;
            wr_idx   <= wr_d;
            rd_idx   <= rd_d;
            q_count  <= count_d;
            q_valid  <= q_valid_d;
            q_data   <= q_data_d;
            mem_req  <= mem_req_d;
            mem_addr <= mem_addr_d;
            if (push) mem[wr_idx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: directed scenarios plus randomized traffic
// compared against a byte-queue reference model.
module tb_prefetch_queue;

    localparam int unsigned DEPTH = 6;

    logic        clk;
    logic        rst_n;
    logic [19:0] b_dir;
    logic        b_flush;
    logic        b_ack;
    logic [7:0]  b_rdata;
    logic        b_pop;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic [7:0]  q_data;
    logic        q_valid;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes held, fetch address, waiting-for-address flag
    logic [7:0]  m_q[$];
    logic [19:0] m_fptr;
    bit          m_loading;

    prefetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .Direction(b_dir), .flush(b_flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(b_ack),
        .mem_rdata(b_rdata), .q_pop(b_pop), .q_data(q_data),
        .q_valid(q_valid), .q_count(q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit exp_req();
        return !m_loading && (m_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fptr    = '0;
        m_loading = 1'b1;
    endtask

    // One clock: advance the model from the pre-edge inputs, then settle
    task automatic cycle();
        bit acc, popd;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (b_flush) begin
            m_q.delete();
            m_loading = 1'b1;
        end else begin
            acc  = exp_req() && b_ack;
            popd = b_pop && (m_q.size() > 0);
            if (m_loading) begin
                m_fptr    = b_dir;
                m_loading = 1'b0;
            end
            if (popd) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(b_rdata);
                m_fptr = m_fptr + 20'd1;
            end
        end
        #1;
        b_rdata = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; b_flush = 0; b_ack = 0; b_pop = 0; b_dir = '0; b_rdata = 8'h5A;
        repeat (3) cycle();
        rst_n = 1'b1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 20'h0) begin
            errors++; $display("FAIL reset_mem: req=%0b addr=%05h exp req=0 addr=00000", mem_req, mem_addr);
        end
        checks++;
        if (q_valid !== 1'b0 || q_count !== 3'd0 || q_data !== 8'h00) begin
            errors++; $display("FAIL reset_queue: valid=%0b count=%0d data=%02h exp 0/0/00", q_valid, q_count, q_data);
        end
    endtask

    task automatic test_fill();
        b_dir = 20'h12345; b_ack = 1'b1;
        cycle();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 20'h12345 + 20'(k)) begin
                errors++; $display("FAIL fill_addr%0d: req=%0b addr=%05h exp req=1 addr=%05h", k, mem_req, mem_addr, 20'h12345 + 20'(k));
            end
            b_dir = 20'($urandom);
            cycle();
        end
        repeat (2) begin
            checks++;
            if (mem_req !== 1'b0 || q_count !== 3'd6 || q_valid !== 1'b1) begin
                errors++; $display("FAIL fill_full: req=%0b count=%0d valid=%0b exp 0/6/1", mem_req, q_count, q_valid);
            end
            cycle();
        end
        checks++;
        if (q_data !== m_q[0]) begin
            errors++; $display("FAIL fill_head: data=%02h exp %02h", q_data, m_q[0]);
        end
    endtask

    task automatic test_pop_full();
        logic [7:0] second;
        second = m_q[1];
        b_ack = 1'b0; b_pop = 1'b1;
        cycle();
        b_pop = 1'b0;
        checks++;
        if (q_count !== 3'd5 || q_data !== second) begin
            errors++; $display("FAIL pop_full_head: count=%0d data=%02h exp 5/%02h", q_count, q_data, second);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 20'h1234B) begin
            errors++; $display("FAIL pop_full_req: req=%0b addr=%05h exp 1/1234B", mem_req, mem_addr);
        end
        b_ack = 1'b1;
        cycle();
        b_ack = 1'b0;
        checks++;
        if (q_count !== 3'd6 || mem_req !== 1'b0) begin
            errors++; $display("FAIL pop_full_refill: count=%0d req=%0b exp 6/0", q_count, mem_req);
        end
    endtask

    task automatic test_wrap();
        logic [19:0] addrs[$];
        logic [7:0]  pushed[$];
        logic [7:0]  popped[$];
        logic [19:0] exp_addr[4];
        exp_addr[0] = 20'hFFFFE; exp_addr[1] = 20'hFFFFF;
        exp_addr[2] = 20'h00000; exp_addr[3] = 20'h00001;
        b_flush = 1'b1;
        cycle();
        b_flush = 1'b0; b_dir = 20'hFFFFE;
        cycle();
        b_ack = 1'b1; b_pop = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (mem_req && addrs.size() < 4) addrs.push_back(mem_addr);
            if (mem_req) pushed.push_back(b_rdata);
            if (q_valid) popped.push_back(q_data);
            cycle();
        end
        b_ack = 1'b0; b_pop = 1'b0;
        checks++;
        if (addrs.size() != 4) begin
            errors++; $display("FAIL wrap_nreq: requests=%0d exp 4", addrs.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (addrs[k] !== exp_addr[k]) begin
                    errors++; $display("FAIL wrap_addr%0d: addr=%05h exp %05h", k, addrs[k], exp_addr[k]);
                end
            end
        end
        checks++;
        if (popped.size() < 4) begin
            errors++; $display("FAIL wrap_npop: popped=%0d exp >=4", popped.size());
        end
        for (int k = 0; k < popped.size() && k < pushed.size(); k++) begin
            checks++;
            if (popped[k] !== pushed[k]) begin
                errors++; $display("FAIL wrap_order%0d: data=%02h exp %02h", k, popped[k], pushed[k]);
            end
        end
    endtask

    task automatic test_flush();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL flush_pre_req: req=%0b exp 1", mem_req);
        end
        b_flush = 1'b1; b_ack = 1'b1; b_pop = 1'b1;
        cycle();
        b_flush = 1'b0; b_ack = 1'b0; b_pop = 1'b0; b_dir = 20'h0F000;
        checks++;
        if (q_valid !== 1'b0 || q_count !== 3'd0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL flush_clear: valid=%0b count=%0d req=%0b exp 0/0/0", q_valid, q_count, mem_req);
        end
        cycle();
        b_dir = 20'hABCDE;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 20'h0F000) begin
            errors++; $display("FAIL flush_newaddr: req=%0b addr=%05h exp 1/0F000", mem_req, mem_addr);
        end
        cycle();
        checks++;
        if (mem_addr !== 20'h0F000) begin
            errors++; $display("FAIL flush_addr_hold: addr=%05h exp 0F000", mem_addr);
        end
    endtask

    task automatic test_simul();
        logic [7:0] acked[$];
        b_ack = 1'b1;
        repeat (3) begin
            acked.push_back(b_rdata);
            cycle();
        end
        checks++;
        if (q_count !== 3'd3) begin
            errors++; $display("FAIL simul_pre: count=%0d exp 3", q_count);
        end
        b_pop = 1'b1;
        acked.push_back(b_rdata);
        cycle();
        void'(acked.pop_front());
        b_ack = 1'b0; b_pop = 1'b0;
        checks++;
        if (q_count !== 3'd3) begin
            errors++; $display("FAIL simul_count: count=%0d exp 3", q_count);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (q_valid !== 1'b1 || q_data !== acked[k]) begin
                errors++; $display("FAIL simul_order%0d: valid=%0b data=%02h exp 1/%02h", k, q_valid, q_data, acked[k]);
            end
            b_pop = 1'b1;
            cycle();
        end
        b_pop = 1'b0;
        checks++;
        if (q_valid !== 1'b0 || q_count !== 3'd0) begin
            errors++; $display("FAIL simul_drain: valid=%0b count=%0d exp 0/0", q_valid, q_count);
        end
    endtask

    task automatic test_empty_pop_reset();
        b_flush = 1'b1;
        cycle();
        b_flush = 1'b0; b_pop = 1'b1; b_dir = 20'h00777;
        cycle();
        cycle();
        b_pop = 1'b0;
        checks++;
        if (q_count !== 3'd0 || q_valid !== 1'b0) begin
            errors++; $display("FAIL empty_pop: count=%0d valid=%0b exp 0/0", q_count, q_valid);
        end
        b_ack = 1'b1;
        cycle();
        cycle();
        checks++;
        if (q_count !== 3'd2 || mem_req !== 1'b1) begin
            errors++; $display("FAIL midfetch: count=%0d req=%0b exp 2/1", q_count, mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 20'h0 || q_valid !== 1'b0 || q_count !== 3'd0 || q_data !== 8'h00) begin
            errors++; $display("FAIL async_reset: req=%0b addr=%05h valid=%0b count=%0d data=%02h exp all 0",
                               mem_req, mem_addr, q_valid, q_count, q_data);
        end
        b_ack = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int pop_bias;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 0) pop_bias = int'($urandom_range(0, 4));
            b_ack   = ($urandom_range(0, 2) != 0);
            b_pop   = (int'($urandom_range(0, 3)) < pop_bias);
            b_flush = ($urandom_range(0, 79) == 0);
            b_dir   = 20'($urandom);
            cycle();
            checks++;
            if (mem_req !== exp_req() || (exp_req() && mem_addr !== m_fptr)) begin
                errors++; $display("FAIL rand_req@%0d: req=%0b addr=%05h exp %0b/%05h", n, mem_req, mem_addr, exp_req(), m_fptr);
            end
            checks++;
            if (q_count !== 3'(m_q.size()) || q_valid !== (m_q.size() > 0)) begin
                errors++; $display("FAIL rand_count@%0d: count=%0d valid=%0b exp %0d", n, q_count, q_valid, m_q.size());
            end
            if (m_q.size() > 0) begin
                checks++;
                if (q_data !== m_q[0]) begin
                    errors++; $display("FAIL rand_data@%0d: data=%02h exp %02h", n, q_data, m_q[0]);
                end
            end
        end
        b_ack = 1'b0; b_pop = 1'b0; b_flush = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_pop_full();
        test_wrap();
        test_flush();
        test_simul();
        test_empty_pop_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
